// File: rtl/mult_div_if.sv
// mult_div_if: operand/command and HI/LO result bundle for mult_div_unit.
// The datapath side drives as master; the unit attaches as slave.
interface mult_div_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] operand_a;
   logic [DATA_WIDTH-1:0] operand_b;
   logic                  hi_we;
   logic                  lo_we;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  busy;
   logic                  done;
   logic                  div_by_zero;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output start, op, operand_a, operand_b,
      output hi_we, lo_we, wdata,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b,
      input  hi_we, lo_we, wdata,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide, one bit per cycle.
// Magnitudes are iterated; signs are applied in a final FIX cycle.
module mult_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   mult_div_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]     state;
   logic [CW-1:0]  count;
   logic [2*W-1:0] acc;
   logic [W-1:0]   opnd;
   logic           is_div;
   logic           sign_a;
   logic           sign_b;
   logic           dz;
   logic [W-1:0]   hi_q;
   logic [W-1:0]   lo_q;
   logic           done_q;
   logic           dz_q;

   logic [W-1:0]   abs_a;
   logic [W-1:0]   abs_b;
   logic [W:0]     mul_sum;
   logic [W:0]     div_shift;
   logic [W:0]     div_trial;
   logic [2*W-1:0] prod_neg;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix;
   logic [W-1:0]   rem_fix;
   logic           neg_res;

   assign abs_a = (bus.op[0] && bus.operand_a[W-1]) ?
                  -bus.operand_a : bus.operand_a;
   assign abs_b = (bus.op[0] && bus.operand_b[W-1]) ?
                  -bus.operand_b : bus.operand_b;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum = {1'b0, acc[2*W-1:W]} +
                    (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});

   // Divide: acc = {remainder, remaining dividend / quotient bits}.
   assign div_shift = {acc[2*W-1:W], acc[W-1]};
   assign div_trial = div_shift - {1'b0, opnd};

   assign neg_res  = sign_a ^ sign_b;
   assign prod_neg = -acc;
   assign prod_fix = neg_res ? prod_neg : acc;
   assign quo_fix  = neg_res ? -acc[W-1:0] : acc[W-1:0];
   assign rem_fix  = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];

   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

   // Control FSM, iteration datapath and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         count  <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         dz     <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  count  <= '0;
                  is_div <= bus.op[1];
                  sign_a <= bus.op[0] & bus.operand_a[W-1];
                  sign_b <= bus.op[0] & bus.operand_b[W-1];
                  dz     <= (bus.operand_b == '0);
                  opnd   <= bus.op[1] ? abs_b : abs_a;
                  acc    <= {{W{1'b0}},
                             (bus.op[1] ? abs_a : abs_b)};
                  state  <= bus.op[1] ? S_DIV : S_MUL;
               end else begin
                  if (bus.hi_we) hi_q <= bus.wdata;
                  if (bus.lo_we) lo_q <= bus.wdata;
               end
            end
            S_MUL: begin
               acc   <= {mul_sum, acc[W-1:1]};
               count <= count + 1'b1;
               if (count == LAST) state <= S_FIX;
            end
            S_DIV: begin
               if (!div_trial[W])
                  acc <= {div_trial[W-1:0], acc[W-2:0], 1'b1};
               else
                  acc <= {div_shift[W-1:0], acc[W-2:0], 1'b0};
               count <= count + 1'b1;
               if (count == LAST) state <= S_FIX;
            end
            S_FIX: begin
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= dz ? {W{1'b1}} : quo_fix;
               end else begin
                  hi_q <= prod_fix[2*W-1:W];
                  lo_q <= prod_fix[W-1:0];
               end
               done_q <= 1'b1;
               dz_q   <= is_div & dz;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table plus hand-written sequences
// for mid-operation starts, reset abort and back-to-back issue.
module tb_mult_div_unit;
   logic clk;
   logic rst;

   mult_div_if #(.DATA_WIDTH(32)) bus ();

   mult_div_unit #(.DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   localparam logic [1:0] MULTU = 2'b00;
   localparam logic [1:0] MULT  = 2'b01;
   localparam logic [1:0] DIVU  = 2'b10;
   localparam logic [1:0] DIV   = 2'b11;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      bus.start     = 1'b1;
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      tick();
      bus.start     = 1'b0;
      bus.operand_a = 32'hDEAD_BEEF;
      bus.operand_b = 32'h0BAD_F00D;
   endtask

   task automatic wait_done(output int edges, output bit busy_ok);
      edges   = 0;
      busy_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         edges++;
         if (bus.done) begin
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy || bus.div_by_zero) busy_ok = 1'b0;
      end
   endtask

   vec_t vecs[12];

   initial begin
      int  edges;
      bit  busy_ok;
      bit  stable;
      int  pulses;
      logic [31:0] hi_prev;

      vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{MULT, 32'hFFFFFFFD, 32'd7,
                   32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{DIV, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{DIV, 32'h80000000, 32'hFFFFFFFF,
                   32'h00000000, 32'h80000000, 1'b0};
      vecs[4]  = '{DIVU, 32'd100, 32'd0,
                   32'd100, 32'hFFFFFFFF, 1'b1};
      vecs[5]  = '{DIVU, 32'd100, 32'd7,
                   32'd2, 32'd14, 1'b0};
      vecs[6]  = '{MULT, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h00000000, 1'b0};
      vecs[7]  = '{DIV, 32'd7, 32'hFFFFFFFE,
                   32'd1, 32'hFFFFFFFD, 1'b0};
      vecs[8]  = '{DIV, 32'hFFFFFFFB, 32'd0,
                   32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
      vecs[9]  = '{MULTU, 32'd12345, 32'd6789,
                   32'd0, 32'h04FED79D, 1'b0};
      vecs[10] = '{MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'd0, 32'd1, 1'b0};
      vecs[11] = '{DIVU, 32'hFFFFFFFF, 32'd1,
                   32'd0, 32'hFFFFFFFF, 1'b0};

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.op        = 2'b00;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.hi_we     = 1'b0;
      bus.lo_we     = 1'b0;
      bus.wdata     = '0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_dz", 32'(bus.div_by_zero), 32'd0);
      check("rst_hi", bus.hi, 32'd0);
      check("rst_lo", bus.lo, 32'd0);

      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'h0000ABCD;
      tick();
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      check("mt_both_hi", bus.hi, 32'h0000ABCD);
      check("mt_both_lo", bus.lo, 32'h0000ABCD);

      for (int i = 0; i < 12; i++) begin
         hi_prev = bus.hi;
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("v%0d busy_e0", i), 32'(bus.busy), 32'd1);
         check($sformatf("v%0d hi_hold", i), bus.hi, hi_prev);
         wait_done(edges, busy_ok);
         check($sformatf("v%0d latency", i), edges, 32'd33);
         check($sformatf("v%0d busy", i), 32'(busy_ok), 32'd1);
         check($sformatf("v%0d hi", i), bus.hi, vecs[i].hi);
         check($sformatf("v%0d lo", i), bus.lo, vecs[i].lo);
         check($sformatf("v%0d dz", i), 32'(bus.div_by_zero),
               32'(vecs[i].dz));
         tick();
         check($sformatf("v%0d done_1cyc", i), 32'(bus.done), 32'd0);
         check($sformatf("v%0d dz_low", i), 32'(bus.div_by_zero),
               32'd0);
      end

      hi_prev = bus.hi;
      start_op(DIVU, 32'd1000, 32'd3);
      repeat (4) tick();
      bus.start     = 1'b1;
      bus.op        = MULTU;
      bus.operand_a = 32'd5;
      bus.operand_b = 32'd5;
      bus.hi_we     = 1'b1;
      bus.wdata     = 32'h55;
      tick();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      check("busy_mt_ignored", bus.hi, hi_prev);
      wait_done(edges, busy_ok);
      check("busy_start_latency", edges, 32'd28);
      check("divu1000_lo", bus.lo, 32'd333);
      check("divu1000_hi", bus.hi, 32'd1);
      tick();
      bus.hi_we = 1'b1;
      bus.wdata = 32'h55;
      tick();
      bus.hi_we = 1'b0;
      check("mthi_idle", bus.hi, 32'h55);
      check("mthi_lo_kept", bus.lo, 32'd333);

      bus.lo_we = 1'b1;
      bus.start = 1'b1;
      bus.op    = MULTU;
      bus.operand_a = 32'd4;
      bus.operand_b = 32'd5;
      bus.wdata = 32'h77;
      tick();
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
      check("start_beats_mt", bus.lo, 32'd333);
      wait_done(edges, busy_ok);
      check("mul4x5_lo", bus.lo, 32'd20);

      start_op(MULTU, 32'd12345, 32'd6789);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_hi", bus.hi, 32'd0);
      check("abort_lo", bus.lo, 32'd0);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) pulses++;
         tick();
      end
      check("abort_no_done", pulses, 32'd0);
      start_op(MULTU, 32'd2, 32'd3);
      wait_done(edges, busy_ok);
      check("fresh_lat", edges, 32'd33);
      check("fresh_lo", bus.lo, 32'd6);
      check("fresh_hi", bus.hi, 32'd0);

      start_op(MULTU, 32'd6, 32'd7);
      wait_done(edges, busy_ok);
      check("b2b_first_lo", bus.lo, 32'd42);
      check("b2b_first_done", 32'(bus.done), 32'd1);
      start_op(MULTU, 32'h00010000, 32'h00010000);
      check("b2b_accept", 32'(bus.busy), 32'd1);
      stable = 1'b1;
      edges  = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.hi !== 32'd0 || bus.lo !== 32'd42) stable = 1'b0;
         tick();
         edges++;
         if (bus.done) break;
      end
      check("b2b_stable", 32'(stable), 32'd1);
      check("b2b_latency", edges, 32'd33);
      check("b2b_hi", bus.hi, 32'd1);
      check("b2b_lo", bus.lo, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
